// File: rtl/points_distance_n.sv
// Euclidean (or squared) distance between two DIM-dimensional signed points.
// Latency: DIM cycles (squared) or DIM+R cycles (distance) from accept to out_valid.
// Backpressure: one job in flight; in_ready low until the result is taken via out_ready.
//
// Ports:
//   CLK2, RST          clock (rising edge), asynchronous active-low reset
//   a, b               points, coordinate i at bits [i*W +: W], two's complement
//   sq_mode            1 = squared distance, 0 = floor(sqrt) distance
//   in_valid/in_ready  job handshake (in_ready == IDLE)
//   res, res_sq        result and the sq_mode it was computed with
//   out_valid/out_ready result handshake (out_valid == DONE)
//   busy               any state other than IDLE
module points_distance_n #(
  parameter int DIM = 3,
  parameter int W   = 16,
  localparam int SW = 2*W + $clog2(DIM)
) (
  input  logic              CLK2,
  input  logic              RST,
  input  logic [DIM*W-1:0]  a,
  input  logic [DIM*W-1:0]  b,
  input  logic              sq_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SW-1:0]     res,
  output logic              res_sq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int R  = (SW + 1) / 2;          // root width / iteration count
  localparam int R2 = 2 * R;                 // radicand padded to an even width
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ROOT, DONE} state_t;

  state_t            state;
  logic [DIM*W-1:0]  a_q, b_q;
  logic              sq_q;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     acc;
  logic [R2-1:0]     rad;
  logic [R+1:0]      rem;
  logic [R-1:0]      root;
  logic [CW-1:0]     cnt;

  // Per-dimension datapath: pick coordinate idx, square the difference.
  logic [W-1:0]          a_i, b_i;
  logic signed [W:0]     d;
  logic signed [2*W+1:0] prod;
  logic [SW-1:0]         acc_nxt;

  always_comb begin
    a_i = '0;
    b_i = '0;
    for (int i = 0; i < DIM; i++) begin
      if (idx == IW'(i)) begin
        a_i = a_q[i*W +: W];
        b_i = b_q[i*W +: W];
      end
    end
  end

  // W+1 bits cannot overflow for a difference of two W-bit signed values.
  assign d       = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});
  assign prod    = d * d;
  // d*d < 2^(2W), so truncating to SW (>= 2W) loses nothing.
  assign acc_nxt = acc + SW'($unsigned(prod));

  // One restoring square-root step: bring down two radicand bits, try
  // subtracting (root<<2)|1. The remainder never exceeds R bits before the
  // shift, so dropping its two top bits here is safe.
  logic [R+1:0] rem_sh, trial, rem_nxt;
  logic         ge;
  logic [R-1:0] root_nxt;

  assign rem_sh   = {rem[R-1:0], rad[R2-1 -: 2]};
  assign trial    = {root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
  assign root_nxt = {root[R-2:0], ge};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK2 or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sq_q   <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      res    <= '0;
      res_sq <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sq_q  <= sq_mode;
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          if (idx == IW'(DIM - 1)) begin
            if (sq_q) begin
              res    <= acc_nxt;
              res_sq <= 1'b1;
              state  <= DONE;
            end else begin
              rad   <= R2'(acc_nxt);
              rem   <= '0;
              root  <= '0;
              cnt   <= '0;
              state <= ROOT;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(R - 1)) begin
            res    <= SW'(root_nxt);
            res_sq <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
